axi_async_fifo_pkt: RTL and testbench

Dual-clock valid/ready FIFO: the next generation of our async FIFO. It adds an optional packet mode with commit/drop semantics and an oversize-packet discard state machine. It also adds per-domain fill levels, programmable almost-full/almost-empty flags and a selectable fall-through or registered output. It sits between a producer on aw_clk and a consumer on ar_clk in stream datapaths.

---
 rtl/axi_async_fifo_pkt_if.sv | 33 +++
 rtl/axi_async_fifo_pkt.sv | 208 ++++++++++++++++++++
 tb/tb_axi_async_fifo_pkt.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_async_fifo_pkt_if.sv
// Producer/consumer bus of the dual-clock packet FIFO. The FIFO takes the
// slave modport; the producer/consumer side takes master.
interface axi_async_fifo_pkt_if #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 12
);
    logic             i_aw_vld;
    logic [DSIZE-1:0] i_aw_data;
    logic             i_aw_last;
    logic             i_aw_drop;
    logic             o_aw_rdy;
    logic [ASIZE:0]   o_aw_level;
    logic             o_aw_afull;
    logic             o_aw_err;
    logic             i_ar_rdy;
    logic             o_ar_vld;
    logic [DSIZE-1:0] o_ar_data;
    logic             o_ar_last;
    logic [ASIZE:0]   o_ar_level;
    logic             o_ar_aempty;

    modport master (
        output i_aw_vld, i_aw_data, i_aw_last, i_aw_drop, i_ar_rdy,
        input  o_aw_rdy, o_aw_level, o_aw_afull, o_aw_err,
               o_ar_vld, o_ar_data, o_ar_last, o_ar_level, o_ar_aempty
    );

    modport slave (
        input  i_aw_vld, i_aw_data, i_aw_last, i_aw_drop, i_ar_rdy,
        output o_aw_rdy, o_aw_level, o_aw_afull, o_aw_err,
               o_ar_vld, o_ar_data, o_ar_last, o_ar_level, o_ar_aempty
    );
endinterface

// File: rtl/axi_async_fifo_pkt.sv
// Dual-clock valid/ready FIFO with optional packet commit/drop, oversize
// discard, per-domain fill levels and fall-through or registered output.
module axi_async_fifo_pkt #(
    parameter int    DSIZE       = 16,
    parameter int    ASIZE       = 12,
    parameter string FALLTHROUGH = "TRUE",
    parameter int    PKT_MODE    = 0,
    parameter int    AFULL_TH    = (1 << ASIZE) - 4,
    parameter int    AEMPTY_TH   = 4,
    parameter int    SYNC_STAGES = 2
) (
    input logic                   aw_clk,
    input logic                   rst,
    input logic                   ar_clk,
    axi_async_fifo_pkt_if.slave   bus
);
    localparam bit             FT       = (FALLTHROUGH == "TRUE");
    localparam bit             PKT      = (PKT_MODE != 0);
    localparam logic [ASIZE:0] DEPTH    = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] AFULL_V  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_V = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] ONE      = {{ASIZE{1'b0}}, 1'b1};

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DSIZE:0] mem_q [0:(1<<ASIZE)-1];

    // ---------------- write domain ----------------
    typedef enum logic [1:0] {W_IDLE, W_NORMAL, W_DISCARD} wstate_e;
    wstate_e wstate_q, wstate_d;

    logic [ASIZE:0]                  wptr_work_q, wptr_work_d;
    logic [ASIZE:0]                  wptr_commit_q, wptr_commit_d;
    logic [ASIZE:0]                  wcommit_gray_q, wcommit_gray_d;
    logic [SYNC_STAGES-1:0][ASIZE:0] rsync_q, rsync_d;
    logic [SYNC_STAGES-1:0]          aw_rel_q, aw_rel_d;
    logic [ASIZE:0]                  aw_level_q, aw_level_d;
    logic                            aw_afull_q, aw_afull_d;
    logic                            aw_err_q, aw_err_d;
    logic [DSIZE:0]                  mem_wdata_d;

    logic [ASIZE:0] rptr_sync, aw_used;
    logic full, aw_en, pending, accept, drop_now, overflow;
    logic aw_rdy, store, commit_beat, rewind;
    logic ar_rst;
    logic [ASIZE:0] rptr_gray_q;

    assign rptr_sync = gray2bin(rsync_q[SYNC_STAGES-1]);
    assign aw_used   = wptr_work_q - rptr_sync;
    assign full      = (aw_used == DEPTH);
    assign aw_en     = aw_rel_q[SYNC_STAGES-1] && !rst;
    assign pending   = (wptr_work_q != wptr_commit_q);
    assign accept    = bus.i_aw_vld && aw_rdy;
    assign drop_now  = PKT && bus.i_aw_drop && pending;
    // Everything held is the current uncommitted packet: it can never fit.
    assign overflow  = PKT && (wstate_q == W_NORMAL) && full && (wptr_commit_q == rptr_sync);

    always_ff @(posedge aw_clk) begin
        if (rst) wstate_q <= W_IDLE;
        else     wstate_q <= wstate_d;
    end

    always_comb begin
        wstate_d = wstate_q;
        if (PKT) begin
            case (wstate_q)
                W_IDLE:    if (store && !bus.i_aw_last) wstate_d = W_NORMAL;
                W_NORMAL:  if (overflow) wstate_d = W_DISCARD;
                           else if (drop_now || commit_beat) wstate_d = W_IDLE;
                W_DISCARD: if (accept && bus.i_aw_last) wstate_d = W_IDLE;
                default:   wstate_d = W_IDLE;
            endcase
        end
    end

    always_comb begin
        aw_rdy      = aw_en && ((wstate_q == W_DISCARD) || !full);
        store       = accept && (wstate_q != W_DISCARD) && !drop_now;
        commit_beat = store && (!PKT || bus.i_aw_last);
        rewind      = drop_now || overflow;
    end

    always_comb begin
        wptr_work_d   = wptr_work_q;
        wptr_commit_d = wptr_commit_q;
        if (store)       wptr_work_d   = wptr_work_q + ONE;
        if (commit_beat) wptr_commit_d = wptr_work_q + ONE;
        if (rewind)      wptr_work_d   = wptr_commit_q;
        wcommit_gray_d = bin2gray(wptr_commit_d);
        rsync_d        = {rsync_q[SYNC_STAGES-2:0], rptr_gray_q};
        aw_rel_d       = {aw_rel_q[SYNC_STAGES-2:0], !ar_rst};
        aw_level_d     = aw_used;
        aw_afull_d     = (aw_used >= AFULL_V);
        aw_err_d       = overflow;
        mem_wdata_d    = {bus.i_aw_last, bus.i_aw_data};
    end

    always_ff @(posedge aw_clk) begin
        if (rst) begin
            wptr_work_q    <= '0;
            wptr_commit_q  <= '0;
            wcommit_gray_q <= '0;
            rsync_q        <= '0;
            aw_rel_q       <= '0;
            aw_level_q     <= '0;
            aw_afull_q     <= 1'b0;
            aw_err_q       <= 1'b0;
        end else begin
            wptr_work_q    <= wptr_work_d;
            wptr_commit_q  <= wptr_commit_d;
            wcommit_gray_q <= wcommit_gray_d;
            rsync_q        <= rsync_d;
            aw_rel_q       <= aw_rel_d;
            aw_level_q     <= aw_level_d;
            aw_afull_q     <= aw_afull_d;
            aw_err_q       <= aw_err_d;
        end
    end

    always_ff @(posedge aw_clk) begin
        if (store) mem_q[wptr_work_q[ASIZE-1:0]] <= mem_wdata_d;
    end

    assign bus.o_aw_rdy   = aw_rdy;
    assign bus.o_aw_level = rst ? '0 : aw_level_q;
    assign bus.o_aw_afull = !rst && aw_afull_q;
    assign bus.o_aw_err   = !rst && aw_err_q;

    // ---------------- read domain ----------------
    logic [SYNC_STAGES-1:0]          ar_rst_q, ar_rst_d;
    logic [SYNC_STAGES-1:0][ASIZE:0] wsync_q, wsync_d;
    logic [ASIZE:0]                  rptr_q, rptr_d, rptr_gray_d;
    logic [ASIZE:0]                  ar_level_q, ar_level_d;
    logic                            ar_aempty_q, ar_aempty_d;
    logic                            out_vld_q, out_vld_d;
    logic [DSIZE:0]                  out_word_q, out_word_d;

    logic [ASIZE:0] wcommit_sync, ar_used;
    logic           empty, pop_mem, ar_vld;
    logic [DSIZE:0] head_word, ar_word;

    // The reset synchroniser itself is never reset; it just follows rst.
    assign ar_rst_d = {ar_rst_q[SYNC_STAGES-2:0], rst};
    always_ff @(posedge ar_clk) ar_rst_q <= ar_rst_d;
    assign ar_rst = ar_rst_q[SYNC_STAGES-1];

    assign wcommit_sync = gray2bin(wsync_q[SYNC_STAGES-1]);
    assign ar_used      = wcommit_sync - rptr_q;
    assign empty        = (ar_used == '0);
    assign head_word    = mem_q[rptr_q[ASIZE-1:0]];

    always_comb begin
        out_vld_d  = out_vld_q;
        out_word_d = out_word_q;
        pop_mem    = 1'b0;
        if (FT) begin
            pop_mem = !empty && bus.i_ar_rdy;
        end else if (!out_vld_q || bus.i_ar_rdy) begin
            // Refill the output register in the same cycle it drains.
            out_vld_d = !empty;
            pop_mem   = !empty;
            if (!empty) out_word_d = head_word;
        end
        rptr_d      = pop_mem ? rptr_q + ONE : rptr_q;
        rptr_gray_d = bin2gray(rptr_d);
        wsync_d     = {wsync_q[SYNC_STAGES-2:0], wcommit_gray_q};
        ar_level_d  = ar_used;
        ar_aempty_d = (ar_used <= AEMPTY_V);
    end

    always_ff @(posedge ar_clk) begin
        if (ar_rst) begin
            rptr_q      <= '0;
            rptr_gray_q <= '0;
            wsync_q     <= '0;
            ar_level_q  <= '0;
            ar_aempty_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_word_q  <= '0;
        end else begin
            rptr_q      <= rptr_d;
            rptr_gray_q <= rptr_gray_d;
            wsync_q     <= wsync_d;
            ar_level_q  <= ar_level_d;
            ar_aempty_q <= ar_aempty_d;
            out_vld_q   <= out_vld_d;
            out_word_q  <= out_word_d;
        end
    end

    assign ar_vld  = FT ? !empty : out_vld_q;
    assign ar_word = FT ? head_word : out_word_q;

    assign bus.o_ar_vld    = !ar_rst && ar_vld;
    assign bus.o_ar_data   = ar_rst ? '0 : ar_word[DSIZE-1:0];
    assign bus.o_ar_last   = !ar_rst && ar_word[DSIZE];
    assign bus.o_ar_level  = ar_rst ? '0 : ar_level_q;
    assign bus.o_ar_aempty = !ar_rst && ar_aempty_q;
endmodule

// File: tb/tb_axi_async_fifo_pkt.sv
// Scoreboard bench: dut_a is the default streaming FIFO, dut_b a 16-deep
// packet-mode FIFO with registered output.
module tb_axi_async_fifo_pkt;
    logic aw_clk = 1'b0;
    logic ar_clk = 1'b0;
    logic rst    = 1'b1;

    always #5 aw_clk = ~aw_clk;
    always #7 ar_clk = ~ar_clk;

    axi_async_fifo_pkt_if #(.DSIZE(16), .ASIZE(12)) ifa ();
    axi_async_fifo_pkt_if #(.DSIZE(16), .ASIZE(4))  ifb ();

    axi_async_fifo_pkt #(.DSIZE(16), .ASIZE(12), .FALLTHROUGH("TRUE"), .PKT_MODE(0)) dut_a (
        .aw_clk(aw_clk), .rst(rst), .ar_clk(ar_clk), .bus(ifa.slave));

    axi_async_fifo_pkt #(.DSIZE(16), .ASIZE(4), .FALLTHROUGH("FALSE"), .PKT_MODE(1)) dut_b (
        .aw_clk(aw_clk), .rst(rst), .ar_clk(ar_clk), .bus(ifb.slave));

    int errors = 0;
    int checks = 0;
    int err_cnt_a = 0;
    int err_cnt_b = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] ea, eb;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Scoreboard monitors: a transfer is seen at the negedge before the edge that takes it.
    always @(negedge ar_clk) begin
        if (ifa.o_ar_vld === 1'b1 && ifa.i_ar_rdy === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_pop: got data %h, expected no data", ifa.o_ar_data);
            end else begin
                ea = qa.pop_front();
                if (ifa.o_ar_data !== ea[15:0]) begin
                    errors++;
                    $display("FAIL a_pop: got data %h, expected %h", ifa.o_ar_data, ea[15:0]);
                end
            end
        end
        if (ifb.o_ar_vld === 1'b1 && ifb.i_ar_rdy === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_pop: got data %h last %b, expected no data", ifb.o_ar_data, ifb.o_ar_last);
            end else begin
                eb = qb.pop_front();
                if ({ifb.o_ar_last, ifb.o_ar_data} !== eb) begin
                    errors++;
                    $display("FAIL b_pop: got last %b data %h, expected last %b data %h",
                             ifb.o_ar_last, ifb.o_ar_data, eb[16], eb[15:0]);
                end
            end
        end
    end

    always @(negedge aw_clk) begin
        if (ifa.o_aw_err === 1'b1) err_cnt_a++;
        if (ifb.o_aw_err === 1'b1) err_cnt_b++;
    end

    task automatic wr_a(input logic [15:0] d);
        int n = 0;
        bit ok = 1'b0;
        ifa.i_aw_vld = 1'b1;
        ifa.i_aw_data = d;
        while (!ok && n < 200) begin
            @(negedge aw_clk);
            ok = ifa.o_aw_rdy;
            @(posedge aw_clk); #1;
            n++;
        end
        ifa.i_aw_vld = 1'b0;
        if (!ok) chk("a_write_timeout", 0, 1);
    endtask

    task automatic wr_b(input logic [15:0] d, input logic last);
        int n = 0;
        bit ok = 1'b0;
        ifb.i_aw_vld = 1'b1;
        ifb.i_aw_data = d;
        ifb.i_aw_last = last;
        while (!ok && n < 200) begin
            @(negedge aw_clk);
            ok = ifb.o_aw_rdy;
            @(posedge aw_clk); #1;
            n++;
        end
        ifb.i_aw_vld = 1'b0;
        ifb.i_aw_last = 1'b0;
        if (!ok) chk("b_write_timeout", 0, 1);
    endtask

    task automatic set_rdy(input bit a, input bit v);
        @(posedge ar_clk); #1;
        if (a) ifa.i_ar_rdy = v;
        else   ifb.i_ar_rdy = v;
        @(posedge aw_clk); #1;
    endtask

    task automatic drain(input bit a, input string nm);
        int n = 0;
        while (((a && qa.size() != 0) || (!a && qb.size() != 0)) && n < 8000) begin
            @(posedge ar_clk);
            n++;
        end
        chk(nm, a ? qa.size() : qb.size(), 0);
        repeat (6) @(posedge ar_clk);
        @(posedge aw_clk); #1;
    endtask

    task automatic wait_release(input string nm);
        int n = 0;
        while (!(ifa.o_aw_rdy === 1'b1 && ifb.o_aw_rdy === 1'b1) && n < 12) begin
            @(negedge aw_clk);
            n++;
        end
        chk(nm, int'(ifa.o_aw_rdy === 1'b1 && ifb.o_aw_rdy === 1'b1), 1);
        @(posedge aw_clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifa.i_aw_vld = 0; ifa.i_aw_data = '0; ifa.i_aw_last = 0; ifa.i_aw_drop = 0; ifa.i_ar_rdy = 0;
        ifb.i_aw_vld = 0; ifb.i_aw_data = '0; ifb.i_aw_last = 0; ifb.i_aw_drop = 0; ifb.i_ar_rdy = 0;

        // Reset state
        repeat (10) @(posedge aw_clk); #1;
        chk("rst_a_aw_rdy",   int'(ifa.o_aw_rdy), 0);
        chk("rst_a_ar_vld",   int'(ifa.o_ar_vld), 0);
        chk("rst_a_aw_level", int'(ifa.o_aw_level), 0);
        chk("rst_a_ar_level", int'(ifa.o_ar_level), 0);
        chk("rst_a_afull",    int'(ifa.o_aw_afull), 0);
        chk("rst_a_aempty",   int'(ifa.o_ar_aempty), 0);
        chk("rst_b_aw_rdy",   int'(ifb.o_aw_rdy), 0);
        chk("rst_b_ar_vld",   int'(ifb.o_ar_vld), 0);
        chk("rst_b_err",      int'(ifb.o_aw_err), 0);
        rst = 1'b0;
        wait_release("release_rdy");

        // Streaming 0..4095 with reader always ready
        set_rdy(1, 1);
        for (int i = 0; i < 4096; i++) begin
            qa.push_back({1'b0, 16'(i)});
            wr_a(16'(i));
        end
        drain(1, "a_stream_drain");
        chk("a_stream_vld_low", int'(ifa.o_ar_vld), 0);
        chk("a_stream_level0",  int'(ifa.o_aw_level), 0);

        // Reader stalled: fill to capacity, thresholds, then release
        set_rdy(1, 0);
        for (int i = 0; i < 4091; i++) begin
            qa.push_back({1'b0, 16'(i) ^ 16'hA5A5});
            wr_a(16'(i) ^ 16'hA5A5);
        end
        repeat (4) @(posedge aw_clk); #1;
        chk("a_level_4091", int'(ifa.o_aw_level), 4091);
        chk("a_afull_4091", int'(ifa.o_aw_afull), 0);
        qa.push_back({1'b0, 16'(4091) ^ 16'hA5A5});
        wr_a(16'(4091) ^ 16'hA5A5);
        repeat (4) @(posedge aw_clk); #1;
        chk("a_level_4092", int'(ifa.o_aw_level), 4092);
        chk("a_afull_4092", int'(ifa.o_aw_afull), 1);
        for (int i = 4092; i < 4096; i++) begin
            qa.push_back({1'b0, 16'(i) ^ 16'hA5A5});
            wr_a(16'(i) ^ 16'hA5A5);
        end
        repeat (4) @(posedge aw_clk); #1;
        chk("a_full_rdy",   int'(ifa.o_aw_rdy), 0);
        chk("a_full_level", int'(ifa.o_aw_level), 4096);
        chk("a_full_afull", int'(ifa.o_aw_afull), 1);
        @(posedge ar_clk); #1;
        ifa.i_ar_rdy = 1'b1;
        @(posedge ar_clk);
        n = 0;
        while (ifa.o_aw_rdy !== 1'b1 && n < 4) begin
            @(negedge aw_clk);
            n++;
        end
        chk("a_rdy_after_pop", int'(ifa.o_aw_rdy === 1'b1), 1);
        @(posedge aw_clk); #1;
        drain(1, "a_full_drain");

        // Packet mode: 5-beat packet invisible until its last beat
        set_rdy(0, 1);
        for (int i = 10; i <= 14; i++) qb.push_back({(i == 14), 16'(i)});
        for (int i = 10; i <= 13; i++) wr_b(16'(i), 1'b0);
        repeat (8) @(posedge ar_clk); #1;
        chk("b_vld_before_last", int'(ifb.o_ar_vld), 0);
        @(posedge aw_clk); #1;
        wr_b(16'd14, 1'b1);
        drain(0, "b_pkt5_drain");

        // Packet mode: 3 beats then drop, then packet 20,21
        wr_b(16'd1, 1'b0);
        wr_b(16'd2, 1'b0);
        wr_b(16'd3, 1'b0);
        ifb.i_aw_drop = 1'b1;
        @(posedge aw_clk); #1;
        ifb.i_aw_drop = 1'b0;
        repeat (4) @(posedge aw_clk); #1;
        chk("b_level_after_drop", int'(ifb.o_aw_level), 0);
        qb.push_back({1'b0, 16'd20});
        qb.push_back({1'b1, 16'd21});
        wr_b(16'd20, 1'b0);
        wr_b(16'd21, 1'b1);
        drain(0, "b_drop_drain");

        // Oversize packet: 20 beats into 16 words
        for (int i = 0; i < 20; i++) wr_b(16'(100 + i), (i == 19));
        repeat (8) @(posedge ar_clk); #1;
        chk("b_err_pulses",     err_cnt_b, 1);
        chk("b_oversize_vld",   int'(ifb.o_ar_vld), 0);
        chk("b_oversize_level", int'(ifb.o_aw_level), 0);
        @(posedge aw_clk); #1;
        qb.push_back({1'b0, 16'd7});
        qb.push_back({1'b1, 16'd8});
        wr_b(16'd7, 1'b0);
        wr_b(16'd8, 1'b1);
        drain(0, "b_after_oversize_drain");

        // Reset mid-stream with 100 words stored
        set_rdy(1, 0);
        for (int i = 0; i < 100; i++) wr_a(16'(i + 300));
        repeat (6) @(posedge ar_clk); #1;
        chk("a_pre_rst_vld",   int'(ifa.o_ar_vld), 1);
        chk("a_pre_rst_level", int'(ifa.o_ar_level), 100);
        @(posedge aw_clk); #1;
        rst = 1'b1;
        n = 0;
        while (ifa.o_ar_vld !== 1'b0 && n < 3) begin
            @(negedge ar_clk);
            n++;
        end
        chk("a_rst_vld_fall", int'(ifa.o_ar_vld), 0);
        repeat (10) @(posedge aw_clk); #1;
        rst = 1'b0;
        wait_release("release_rdy_2");
        chk("a_post_rst_aw_level", int'(ifa.o_aw_level), 0);
        chk("a_post_rst_ar_level", int'(ifa.o_ar_level), 0);
        chk("a_post_rst_vld",      int'(ifa.o_ar_vld), 0);
        qa.push_back({1'b0, 16'h55AA});
        wr_a(16'h55AA);
        set_rdy(1, 1);
        drain(1, "a_post_rst_drain");

        chk("a_no_err", err_cnt_a, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
